mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data/instruction memory between two requesters:
  - the CPU multicycle control path (CPU port);
  - an external loader/debug port (EXT port).
- Per-cycle round-robin grant with a bounded EXT burst length.
- EXT can take exclusive hold of memory, e.g. for program load, via a SHARE/DRAIN/OWN state machine.
- Sits between the CPU address/data muxes and the memory instance; stalls the CPU control FSM when the CPU loses arbitration.

Parameters:
- ADDR_WIDTH, 10, memory word-address width; mem_addr is the low ADDR_WIDTH bits of the 16-bit request address.
- DATA_WIDTH, 16, memory word width.
- MAX_EXT_BURST, 4, max consecutive EXT grants in SHARE while CPU is requesting; range 1-15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU requests a memory access this cycle.
- cpu_we  in  1  CPU access is a write.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_stall  out  1  cpu_req high and not granted; CPU control FSM must hold state.
- cpu_rvalid  out  1  cpu_rdata valid (read granted in previous cycle).
- cpu_rdata  out  DATA_WIDTH  read data to CPU.
- ext_req  in  1  EXT requests an access.
- ext_we  in  1  EXT access is a write.
- ext_addr  in  16  EXT address.
- ext_wdata  in  DATA_WIDTH  EXT write data.
- ext_gnt  out  1  EXT access accepted this cycle.
- ext_rvalid  out  1  ext_rdata valid.
- ext_rdata  out  DATA_WIDTH  read data to EXT.
- ext_hold  in  1  EXT requests exclusive ownership.
- hold_ack  out  1  exclusive ownership granted (state OWN).
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_data  out  DATA_WIDTH  to memory data.
- mem_we  out  1  to memory we.
- mem_q  in  DATA_WIDTH  memory read data, valid one cycle after address.

Behaviour:
- Reset (synchronous): state=SHARE, last_winner=EXT (so CPU wins the first conflict), burst_cnt=0, rd_owner pipeline cleared.
  - All outputs are 0 the cycle after Reset, except cpu_stall, which follows its combinational definition.
- Grant is combinational from the current-cycle requests and registered state; an access is issued in the same cycle it is granted.
- SHARE state:
  - Only one requester → it is granted.
  - Both request → grant goes to the one that is not last_winner.
    - Exception: EXT keeps the grant while burst_cnt < MAX_EXT_BURST and last_winner=EXT and ext_req is held continuously.
    - When burst_cnt reaches MAX_EXT_BURST, CPU is granted for exactly one cycle.
  - burst_cnt counts consecutive EXT grants that occur while cpu_req is high. It clears on any CPU grant or on any cycle with ext_req low.
- Mux: mem_addr, mem_data and mem_we come from the granted port. With no grant, mem_we=0 and the address/data hold their previous values.
- Writes are never issued unless granted; mem_we = granted_req & granted_we.
- Read return:
  - rd_owner register records the granted port for a granted read.
  - Next cycle: that port's rvalid=1 and its rdata=mem_q; the other port's rdata holds its last value.
  - A granted write produces no rvalid.
- cpu_stall = cpu_req & ~cpu_grant. It is asserted in DRAIN and OWN whenever cpu_req is high.
- Hold state machine:
  - SHARE → DRAIN when ext_hold=1.
  - DRAIN: no new CPU grants; EXT may be granted. Moves to OWN the next cycle; the one DRAIN cycle lets any CPU read granted in the last SHARE cycle return cpu_rvalid.
  - OWN: hold_ack=1; EXT always granted on ext_req; CPU never granted.
  - OWN → SHARE when ext_hold=0. hold_ack drops in that same transition, and last_winner is set to EXT so CPU wins the next conflict.
  - ext_hold dropped while in DRAIN → return to SHARE.
- Address wrap: addresses truncate modulo 2^ADDR_WIDTH; no error signalling.
- Reset mid-operation: a pending rvalid is cancelled and the state returns to SHARE; a write issued in the reset cycle is still driven to memory.

Test Plan:
- Reset then CPU-only read of addr 0x0005 (mem=0x1234) → cpu_stall=0 that cycle; next cycle cpu_rvalid=1, cpu_rdata=0x1234; ext_rvalid=0.
- Simultaneous cpu_req and ext_req, both reads, right after reset → CPU granted first; next cycle EXT granted and cpu_stall=0, cpu_req dropped; returns arrive in grant order.
- MAX_EXT_BURST=4; ext_req held for 10 cycles with cpu_req high from cycle 0 → grant sequence CPU, E, E, E, E, CPU, E, E, E, E; cpu_stall high exactly on the EXT-grant cycles.
- EXT write 0xBEEF to addr 0x0403 → mem_addr=0x003 (wrap), mem_we=1 for one cycle; a later EXT read of 0x0003 returns 0xBEEF.
- CPU read granted in cycle t with ext_hold rising in t → cpu_rvalid at t+1 (DRAIN); hold_ack=1 at t+2; cpu_req held high stalls through OWN; ext_hold low → next conflict goes to CPU.
- Reset asserted the cycle after a granted read → no rvalid pulse; state SHARE; hold_ack=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of CPU, EXT and memory signals around the memory port arbiter
// Ports (slave = arbiter side):
//   CPU : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_stall/cpu_rvalid/cpu_rdata out
//   EXT : ext_req/ext_we/ext_addr/ext_wdata/ext_hold in, ext_gnt/ext_rvalid/ext_rdata/hold_ack out
//   MEM : mem_q in, mem_addr/mem_data/mem_we out
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [15:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  ext_req;
  logic                  ext_we;
  logic [15:0]           ext_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_hold;
  logic                  hold_ack;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_hold,
    output ext_gnt, ext_rvalid, ext_rdata, hold_ack,
    output mem_addr, mem_data, mem_we,
    input  mem_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_hold,
    input  ext_gnt, ext_rvalid, ext_rdata, hold_ack,
    input  mem_addr, mem_data, mem_we,
    output mem_q
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous single-port memory between the CPU and an EXT loader/debug port
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   Reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave carrying CPU request/return, EXT request/return/hold and memory signals
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_EXT_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_SHARE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OWN   = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_EXT_BURST);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_ext;     // 1: EXT won the most recent grant
  logic                  r_ext_streak;   // EXT was granted in SHARE last cycle
  logic [3:0]            r_burst_cnt;
  logic                  r_cpu_rvalid;
  logic                  r_ext_rvalid;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_ext_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hold_ack;

  logic                  w_cpu_gnt;
  logic                  w_ext_gnt;
  logic                  w_ext_keeps;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic                  w_mem_we;
  logic                  w_unused_addr_bits;

  // Only the low ADDR_WIDTH bits reach memory; upper bits wrap silently.
  assign w_unused_addr_bits = ^{bus.cpu_addr[15:ADDR_WIDTH], bus.ext_addr[15:ADDR_WIDTH]};

  // A streak requires EXT to have won in SHARE on the previous cycle, so the
  // reset value of r_last_ext alone never lets EXT win the first conflict.
  assign w_ext_keeps = r_last_ext && r_ext_streak && (r_burst_cnt < LP_MAX_BURST);

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    case (r_state)
      ST_SHARE: begin
        if (bus.cpu_req && bus.ext_req) begin
          if (!r_last_ext || w_ext_keeps) begin
            w_ext_gnt = 1'b1;
          end else begin
            w_cpu_gnt = 1'b1;
          end
        end else begin
          w_cpu_gnt = bus.cpu_req;
          w_ext_gnt = bus.ext_req;
        end
      end
      default: begin
        // DRAIN and OWN lock the CPU out; EXT is served whenever it asks.
        w_ext_gnt = bus.ext_req;
      end
    endcase
  end

  always_comb begin
    w_next_state = ST_SHARE;
    case (r_state)
      ST_SHARE: w_next_state = bus.ext_hold ? ST_DRAIN : ST_SHARE;
      ST_DRAIN: w_next_state = bus.ext_hold ? ST_OWN : ST_SHARE;
      ST_OWN:   w_next_state = bus.ext_hold ? ST_OWN : ST_SHARE;
      default:  w_next_state = ST_SHARE;
    endcase
  end

  always_comb begin
    w_mem_addr = r_addr;
    w_mem_data = r_data;
    if (w_cpu_gnt) begin
      w_mem_addr = bus.cpu_addr[ADDR_WIDTH-1:0];
      w_mem_data = bus.cpu_wdata;
    end else if (w_ext_gnt) begin
      w_mem_addr = bus.ext_addr[ADDR_WIDTH-1:0];
      w_mem_data = bus.ext_wdata;
    end
    w_mem_we = (w_cpu_gnt && bus.cpu_we) || (w_ext_gnt && bus.ext_we);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= ST_SHARE;
      r_last_ext   <= 1'b1;
      r_ext_streak <= 1'b0;
      r_burst_cnt  <= 4'd0;
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_hold_ack   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_hold_ack <= (w_next_state == ST_OWN);

      // Leaving OWN hands the next conflict back to the CPU.
      if (r_state == ST_OWN && !bus.ext_hold) begin
        r_last_ext <= 1'b1;
      end else if (w_cpu_gnt) begin
        r_last_ext <= 1'b0;
      end else if (w_ext_gnt) begin
        r_last_ext <= 1'b1;
      end

      r_ext_streak <= (r_state == ST_SHARE) && w_ext_gnt;

      if (r_state != ST_SHARE || w_cpu_gnt || !bus.ext_req) begin
        r_burst_cnt <= 4'd0;
      end else if (w_ext_gnt && bus.cpu_req && r_burst_cnt < LP_MAX_BURST) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end

      r_cpu_rvalid <= w_cpu_gnt && !bus.cpu_we;
      r_ext_rvalid <= w_ext_gnt && !bus.ext_we;
      if (r_cpu_rvalid) begin
        r_cpu_rdata <= bus.mem_q;
      end
      if (r_ext_rvalid) begin
        r_ext_rdata <= bus.mem_q;
      end

      r_addr <= w_mem_addr;
      r_data <= w_mem_data;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && !w_cpu_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.cpu_rdata  = r_cpu_rvalid ? bus.mem_q : r_cpu_rdata;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.ext_rvalid = r_ext_rvalid;
  assign bus.ext_rdata  = r_ext_rvalid ? bus.mem_q : r_ext_rdata;
  assign bus.hold_ack   = r_hold_ack;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_data   = w_mem_data;
  assign bus.mem_we     = w_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  logic [15:0] mem [0:1023];

  mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) u_if ();

  mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .MAX_EXT_BURST(4)) u_dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on we, read data one cycle after address.
  always @(posedge clk) begin
    if (u_if.mem_we) mem[u_if.mem_addr] <= u_if.mem_data;
    u_if.mem_q <= mem[u_if.mem_addr];
  end

  task automatic idle_inputs();
    u_if.cpu_req = 1'b0; u_if.cpu_we = 1'b0; u_if.cpu_addr = 16'h0; u_if.cpu_wdata = 16'h0;
    u_if.ext_req = 1'b0; u_if.ext_we = 1'b0; u_if.ext_addr = 16'h0; u_if.ext_wdata = 16'h0;
    u_if.ext_hold = 1'b0;
  endtask

  // Advance to the next negative edge, where inputs change and outputs are sampled.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); idle_inputs(); reset = 1'b1;
    step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (u_if.hold_ack !== 1'b0) begin n_fail++; $display("FAIL reset_hold_ack got=%0h exp=0", u_if.hold_ack); end
    n_cmp++; if (u_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rvalid got=%0h exp=0", u_if.cpu_rvalid); end
    n_cmp++; if (u_if.ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ext_rvalid got=%0h exp=0", u_if.ext_rvalid); end
    n_cmp++; if (u_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%0h exp=0", u_if.mem_we); end
    n_cmp++; if (u_if.mem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_mem_addr got=%0h exp=0", u_if.mem_addr); end
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall got=%0h exp=0", u_if.cpu_stall); end
  endtask

  task automatic test_cpu_read();
    do_reset();
    u_if.cpu_req = 1'b1; u_if.cpu_addr = 16'h0005;
    #1;
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpurd_stall got=%0h exp=0", u_if.cpu_stall); end
    n_cmp++; if (u_if.mem_addr !== 10'h005) begin n_fail++; $display("FAIL cpurd_addr got=%0h exp=005", u_if.mem_addr); end
    step(); u_if.cpu_req = 1'b0;
    #1;
    n_cmp++; if (u_if.cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL cpurd_rvalid got=%0h exp=1", u_if.cpu_rvalid); end
    n_cmp++; if (u_if.cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL cpurd_rdata got=%0h exp=1234", u_if.cpu_rdata); end
    n_cmp++; if (u_if.ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpurd_ext_rvalid got=%0h exp=0", u_if.ext_rvalid); end
    step(); #1;
    n_cmp++; if (u_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpurd_rvalid_drop got=%0h exp=0", u_if.cpu_rvalid); end
    n_cmp++; if (u_if.cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL cpurd_rdata_hold got=%0h exp=1234", u_if.cpu_rdata); end
  endtask

  task automatic test_conflict();
    do_reset();
    u_if.cpu_req = 1'b1; u_if.cpu_addr = 16'h0007;
    u_if.ext_req = 1'b1; u_if.ext_addr = 16'h0009;
    #1;
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL conf_c0_stall got=%0h exp=0", u_if.cpu_stall); end
    n_cmp++; if (u_if.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL conf_c0_ext_gnt got=%0h exp=0", u_if.ext_gnt); end
    n_cmp++; if (u_if.mem_addr !== 10'h007) begin n_fail++; $display("FAIL conf_c0_addr got=%0h exp=007", u_if.mem_addr); end
    step(); u_if.cpu_req = 1'b0;
    #1;
    n_cmp++; if (u_if.ext_gnt !== 1'b1) begin n_fail++; $display("FAIL conf_c1_ext_gnt got=%0h exp=1", u_if.ext_gnt); end
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL conf_c1_stall got=%0h exp=0", u_if.cpu_stall); end
    n_cmp++; if (u_if.mem_addr !== 10'h009) begin n_fail++; $display("FAIL conf_c1_addr got=%0h exp=009", u_if.mem_addr); end
    n_cmp++; if (u_if.cpu_rvalid !== 1'b1 || u_if.cpu_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL conf_c1_cpu_ret got=%0h/%0h exp=1/a5a5", u_if.cpu_rvalid, u_if.cpu_rdata); end
    n_cmp++; if (u_if.ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL conf_c1_ext_rvalid got=%0h exp=0", u_if.ext_rvalid); end
    step(); u_if.ext_req = 1'b0;
    #1;
    n_cmp++; if (u_if.ext_rvalid !== 1'b1 || u_if.ext_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL conf_c2_ext_ret got=%0h/%0h exp=1/5a5a", u_if.ext_rvalid, u_if.ext_rdata); end
    n_cmp++; if (u_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL conf_c2_cpu_rvalid got=%0h exp=0", u_if.cpu_rvalid); end
  endtask

  task automatic test_burst();
    logic exp_ext;
    do_reset();
    u_if.cpu_req = 1'b1; u_if.cpu_addr = 16'h0001;
    u_if.ext_req = 1'b1; u_if.ext_addr = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      exp_ext = (i != 0 && i != 5);
      #1;
      n_cmp++; if (u_if.ext_gnt !== exp_ext) begin n_fail++; $display("FAIL burst_gnt[%0d] got=%0h exp=%0h", i, u_if.ext_gnt, exp_ext); end
      n_cmp++; if (u_if.cpu_stall !== exp_ext) begin n_fail++; $display("FAIL burst_stall[%0d] got=%0h exp=%0h", i, u_if.cpu_stall, exp_ext); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    u_if.ext_req = 1'b1; u_if.ext_we = 1'b1; u_if.ext_addr = 16'h0403; u_if.ext_wdata = 16'hBEEF;
    #1;
    n_cmp++; if (u_if.ext_gnt !== 1'b1) begin n_fail++; $display("FAIL wrap_gnt got=%0h exp=1", u_if.ext_gnt); end
    n_cmp++; if (u_if.mem_we !== 1'b1) begin n_fail++; $display("FAIL wrap_we got=%0h exp=1", u_if.mem_we); end
    n_cmp++; if (u_if.mem_addr !== 10'h003) begin n_fail++; $display("FAIL wrap_addr got=%0h exp=003", u_if.mem_addr); end
    n_cmp++; if (u_if.mem_data !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_data got=%0h exp=beef", u_if.mem_data); end
    step(); u_if.ext_req = 1'b0; u_if.ext_we = 1'b0;
    #1;
    n_cmp++; if (u_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL wrap_we_drop got=%0h exp=0", u_if.mem_we); end
    n_cmp++; if (u_if.ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL wrap_wr_no_rvalid got=%0h exp=0", u_if.ext_rvalid); end
    n_cmp++; if (u_if.mem_addr !== 10'h003) begin n_fail++; $display("FAIL wrap_addr_hold got=%0h exp=003", u_if.mem_addr); end
    step(); u_if.ext_req = 1'b1; u_if.ext_addr = 16'h0003;
    step(); u_if.ext_req = 1'b0;
    #1;
    n_cmp++; if (u_if.ext_rvalid !== 1'b1 || u_if.ext_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_readback got=%0h/%0h exp=1/beef", u_if.ext_rvalid, u_if.ext_rdata); end
  endtask

  task automatic test_hold();
    do_reset();
    u_if.cpu_req = 1'b1; u_if.cpu_addr = 16'h0005; u_if.ext_hold = 1'b1;
    #1;
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL hold_t0_stall got=%0h exp=0", u_if.cpu_stall); end
    step(); #1;
    n_cmp++; if (u_if.cpu_rvalid !== 1'b1 || u_if.cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL hold_t1_ret got=%0h/%0h exp=1/1234", u_if.cpu_rvalid, u_if.cpu_rdata); end
    n_cmp++; if (u_if.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL hold_t1_stall got=%0h exp=1", u_if.cpu_stall); end
    n_cmp++; if (u_if.hold_ack !== 1'b0) begin n_fail++; $display("FAIL hold_t1_ack got=%0h exp=0", u_if.hold_ack); end
    step(); u_if.ext_req = 1'b1; u_if.ext_we = 1'b1; u_if.ext_addr = 16'h0020; u_if.ext_wdata = 16'h0042;
    #1;
    n_cmp++; if (u_if.hold_ack !== 1'b1) begin n_fail++; $display("FAIL hold_t2_ack got=%0h exp=1", u_if.hold_ack); end
    n_cmp++; if (u_if.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL hold_t2_stall got=%0h exp=1", u_if.cpu_stall); end
    n_cmp++; if (u_if.ext_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_t2_ext_gnt got=%0h exp=1", u_if.ext_gnt); end
    n_cmp++; if (u_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_t2_rvalid got=%0h exp=0", u_if.cpu_rvalid); end
    step(); u_if.ext_req = 1'b0; u_if.ext_we = 1'b0; u_if.ext_hold = 1'b0;
    #1;
    n_cmp++; if (u_if.hold_ack !== 1'b1 || u_if.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL hold_t3_own got=%0h/%0h exp=1/1", u_if.hold_ack, u_if.cpu_stall); end
    step(); u_if.ext_req = 1'b1; u_if.ext_addr = 16'h0009;
    #1;
    n_cmp++; if (u_if.hold_ack !== 1'b0) begin n_fail++; $display("FAIL hold_t4_ack got=%0h exp=0", u_if.hold_ack); end
    n_cmp++; if (u_if.cpu_stall !== 1'b0 || u_if.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_t4_conflict got=%0h/%0h exp=0/0", u_if.cpu_stall, u_if.ext_gnt); end
    step(); idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    u_if.ext_hold = 1'b1;
    step(); step(); #1;
    n_cmp++; if (u_if.hold_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_own_ack got=%0h exp=1", u_if.hold_ack); end
    reset = 1'b1;
    step(); reset = 1'b0; u_if.ext_hold = 1'b0; u_if.cpu_req = 1'b1; u_if.cpu_addr = 16'h0005;
    #1;
    n_cmp++; if (u_if.hold_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_clear got=%0h exp=0", u_if.hold_ack); end
    n_cmp++; if (u_if.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_share_grant got=%0h exp=0", u_if.cpu_stall); end
    step(); reset = 1'b1; u_if.cpu_addr = 16'h0007;
    step(); reset = 1'b0; u_if.cpu_req = 1'b0;
    #1;
    n_cmp++; if (u_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_cancel got=%0h exp=0", u_if.cpu_rvalid); end
    n_cmp++; if (u_if.cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL rmid_rdata_clear got=%0h exp=0", u_if.cpu_rdata); end
    step(); reset = 1'b1; u_if.ext_req = 1'b1; u_if.ext_we = 1'b1; u_if.ext_addr = 16'h0011; u_if.ext_wdata = 16'h7777;
    #1;
    n_cmp++; if (u_if.mem_we !== 1'b1 || u_if.mem_addr !== 10'h011) begin n_fail++; $display("FAIL rmid_write got=%0h/%0h exp=1/011", u_if.mem_we, u_if.mem_addr); end
    step(); reset = 1'b0; u_if.ext_we = 1'b0;
    step(); u_if.ext_req = 1'b0;
    #1;
    n_cmp++; if (u_if.ext_rvalid !== 1'b1 || u_if.ext_rdata !== 16'h7777) begin n_fail++; $display("FAIL rmid_write_readback got=%0h/%0h exp=1/7777", u_if.ext_rvalid, u_if.ext_rdata); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    idle_inputs();
    u_if.mem_q = 16'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[5] = 16'h1234;
    mem[7] = 16'hA5A5;
    mem[9] = 16'h5A5A;

    test_reset();
    test_cpu_read();
    test_conflict();
    test_burst();
    test_wrap();
    test_hold();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
